// File: rtl/phase_accumulator_if.sv
// FTW update channel into the phase accumulator: valid/ready handshake.
// Ports: ftw_in (tuning word), ftw_valid (source), ftw_ready (sink).
interface phase_accumulator_if #(
    parameter int ACC_W = 32
);
    logic [ACC_W-1:0] ftw_in;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (
        output ftw_in,
        output ftw_valid,
        input  ftw_ready
    );

    modport slave (
        input  ftw_in,
        input  ftw_valid,
        output ftw_ready
    );
endinterface

// File: rtl/phase_accumulator.sv
// NCO phase generator feeding sine_LUT (which uses phase[31:24]).
// Ports: clk, reset (sync, active-high), enable, clear, ftw (FTW
// handshake, slave), phase_offset, phase, phase_valid, wrap.
// Optional macro PHASE_DITHER_EN adds LFSR dither to the phase LSBs.
module phase_accumulator #(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_FTW = 32'h0100_0000,
    parameter bit               SYNC_UPDATE = 1'b1,
    parameter int               DITHER_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    phase_accumulator_if.slave  ftw,
    input  logic [ACC_W-1:0]    phase_offset,
    output logic [ACC_W-1:0]    phase,
    output logic                phase_valid,
    output logic                wrap
);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nx;
    logic [ACC_W-1:0] ftw_active;
    logic [ACC_W-1:0] ftw_shadow;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             xfer;
    logic             swap;
    logic             swap_cond;
    logic [DITHER_BITS-1:0] dither_lsb;
    logic [ACC_W-1:0] dither;

    assign sum   = {1'b0, acc} + {1'b0, ftw_active};
    assign carry = sum[ACC_W];

    assign ftw.ftw_ready = (state == IDLE) & ~reset;
    assign xfer          = ftw.ftw_valid & ftw.ftw_ready;

    // Wrap-synchronous swap keeps the phase continuous at the LUT seam.
    assign swap_cond = SYNC_UPDATE ? (enable & ~clear & carry)
                                   : enable;

    always_comb begin
        acc_nx = acc;
        if (clear)
            acc_nx = '0;
        else if (enable)
            acc_nx = sum[ACC_W-1:0];
    end

    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer)
                    state_nx = PEND;
            end
            PEND: begin
                if (swap_cond) begin
                    swap     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (enable)
            lfsr <= {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign dither_lsb = lfsr[DITHER_BITS-1:0];
`else
    assign dither_lsb = '0;
`endif

    assign dither = ACC_W'(dither_lsb);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            ftw_active  <= DEFAULT_FTW;
            ftw_shadow  <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            acc         <= acc_nx;
            wrap        <= enable & ~clear & carry;
            phase_valid <= enable & ~clear;
            if (clear)
                phase <= phase_offset;
            else if (enable)
                phase <= acc_nx + phase_offset + dither;
            if (xfer)
                ftw_shadow <= ftw.ftw_in;
            if (swap)
                ftw_active <= ftw_shadow;
        end
    end

endmodule
